// File: rtl/w6debug_link_if.sv
// w6debug_link_if: signal bundle between the serial debug link, the host-side
// debug header pins and the on-chip debug controller.
//   io_*        host serial side (io_clk/io_dir/io_in from host, io_cts/io_rts/io_out to host)
//   rx_*        core receive side, ready/valid, first-word fall-through
//   tx_*        core transmit side, ready/valid
//   rx_overrun, rx_parity_err, err_clr   sticky error flags and their clear
// Modports: slave = the link block, master = whoever drives host pins and core side.
interface w6debug_link_if #(
    parameter int WIDTH = 8
);
    logic             io_clk;
    logic             io_dir;
    logic             io_in;
    logic             io_cts;
    logic             io_rts;
    logic             io_out;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             rx_overrun;
    logic             rx_parity_err;
    logic             err_clr;

    modport slave (
        input  io_clk, io_dir, io_in, rx_ready, tx_data, tx_valid, err_clr,
        output io_cts, io_rts, io_out, rx_data, rx_valid, tx_ready,
               rx_overrun, rx_parity_err
    );

    modport master (
        output io_clk, io_dir, io_in, rx_ready, tx_data, tx_valid, err_clr,
        input  io_cts, io_rts, io_out, rx_data, rx_valid, tx_ready,
               rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/w6debug_link.sv
// w6debug_link: host-clocked serial debug link with word FIFOs in both directions.
// The host drives io_clk/io_dir/io_in; io_clk is resynchronised and debounced and
// its debounced rising edge is the bit event. Words are shifted MSB-first.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   bus          w6debug_link_if.slave (host pins, core ready/valid, error flags)
// Parameters: WIDTH (word bits), RX_DEPTH / TX_DEPTH (FIFO words, power of 2),
//   DEB_CYCLES (differing samples needed to toggle the debounced io_clk).
//   WIDTH must match the WIDTH of the connected interface instance.
// Optional feature macro: W6DEBUG_PARITY_EN -- appends an even-parity bit to every
//   word on the wire; without it rx_parity_err is tied 0.
module w6debug_link #(
    parameter int WIDTH      = 8,
    parameter int RX_DEPTH   = 4,
    parameter int TX_DEPTH   = 4,
    parameter int DEB_CYCLES = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    w6debug_link_if.slave bus
);
`ifdef W6DEBUG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int BITS  = WIDTH + PAR;          // bits per word on the wire
    localparam int CNT_W = $clog2(BITS + 1);
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_PW = RX_AW + 1;            // extra wrap bit
    localparam int TX_PW = TX_AW + 1;

    // ---------------- input synchronisers ----------------
    logic [1:0] clk_sy, dir_sy, in_sy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sy <= '0;
            dir_sy <= '0;
            in_sy  <= '0;
        end else begin
            clk_sy <= {clk_sy[0], bus.io_clk};
            dir_sy <= {dir_sy[0], bus.io_dir};
            in_sy  <= {in_sy[0],  bus.io_in};
        end
    end

    // ---------------- debounce ----------------
    logic             deb_clk;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_hit;
    logic             bit_evt;

    // deb_hit marks the DEB_CYCLES-th consecutive differing sample
    assign deb_hit = (clk_sy[1] != deb_clk) && (deb_cnt == DEB_W'(DEB_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_clk <= 1'b0;
            deb_cnt <= '0;
            bit_evt <= 1'b0;
        end else begin
            bit_evt <= deb_hit & ~deb_clk;   // only the 0->1 toggle is a bit event
            if (clk_sy[1] == deb_clk) begin
                deb_cnt <= '0;
            end else if (deb_hit) begin
                deb_clk <= ~deb_clk;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // dir/in were stable for the whole debounce window, so the synced copies
    // are valid in the event cycle
    logic rx_ev, tx_ev;
    assign rx_ev = bit_evt &  dir_sy[1];
    assign tx_ev = bit_evt & ~dir_sy[1];

    // ---------------- RX shifter ----------------
    logic [BITS-1:0]  rx_shift;
    logic [BITS-1:0]  rx_frame;
    logic [CNT_W-1:0] rx_cnt;
    logic             rx_last, par_ok, rx_done, perr_set;
    logic [WIDTH-1:0] rx_word;

    assign rx_frame = {rx_shift[BITS-2:0], in_sy[1]};
    assign rx_last  = rx_ev && (rx_cnt == CNT_W'(BITS - 1));
    assign rx_word  = rx_frame[BITS-1 -: WIDTH];
`ifdef W6DEBUG_PARITY_EN
    assign par_ok   = ~(^rx_frame);          // even parity over data + parity bit
`else
    assign par_ok   = 1'b1;
`endif
    assign rx_done  = rx_last & par_ok;
    assign perr_set = rx_last & ~par_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_shift <= '0;
            rx_cnt   <= '0;
        end else if (rx_ev) begin
            rx_shift <= rx_frame;
            rx_cnt   <= rx_last ? '0 : rx_cnt + CNT_W'(1);
        end else if (tx_ev && rx_cnt != '0) begin
            rx_cnt   <= '0;                  // direction switch drops partial RX word
        end
    end

    // ---------------- RX FIFO ----------------
    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [RX_PW-1:0] rx_wp, rx_rp;
    logic             rx_empty, rx_full, rx_pop, rx_push, rx_drop;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[RX_AW] != rx_rp[RX_AW]) &&
                      (rx_wp[RX_AW-1:0] == rx_rp[RX_AW-1:0]);
    assign rx_pop   = !rx_empty && bus.rx_ready;
    // a pop in the same cycle frees the head slot, so a full FIFO still accepts
    assign rx_push  = rx_done && (!rx_full || rx_pop);
    assign rx_drop  = rx_done && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wp[RX_AW-1:0]] <= rx_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_PW'(1);
            if (rx_pop)  rx_rp <= rx_rp + RX_PW'(1);
        end
    end

    assign bus.rx_data  = rx_mem[rx_rp[RX_AW-1:0]];
    assign bus.rx_valid = !rx_empty;

    // ---------------- TX FIFO ----------------
    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [TX_PW-1:0] tx_wp, tx_rp;
    logic             tx_empty, tx_full, tx_push, tx_pop, tx_loaded;
    logic [WIDTH-1:0] tx_head;
    logic [BITS-1:0]  tx_load;

    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[TX_AW] != tx_rp[TX_AW]) &&
                      (tx_wp[TX_AW-1:0] == tx_rp[TX_AW-1:0]);
    assign tx_push  = bus.tx_valid && !tx_full;
    assign tx_pop   = !tx_loaded && !tx_empty;   // refill shifter as soon as it drains
    assign tx_head  = tx_mem[tx_rp[TX_AW-1:0]];
`ifdef W6DEBUG_PARITY_EN
    assign tx_load  = {tx_head, ^tx_head};
`else
    assign tx_load  = tx_head;
`endif

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TX_AW-1:0]] <= bus.tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_PW'(1);
            if (tx_pop)  tx_rp <= tx_rp + TX_PW'(1);
        end
    end

    assign bus.tx_ready = !tx_full;

    // ---------------- TX shifter ----------------
    logic [BITS-1:0]  tx_shift;
    logic [CNT_W-1:0] tx_cnt;
    logic             io_out_q;

    assign tx_loaded = (tx_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift <= '0;
            tx_cnt   <= '0;
            io_out_q <= 1'b0;
        end else begin
            // tx_pop needs an empty shifter, so it never coincides with a shift
            if (tx_pop) begin
                tx_shift <= tx_load;
                tx_cnt   <= CNT_W'(BITS);
            end else if (tx_ev && tx_loaded) begin
                tx_shift <= {tx_shift[BITS-2:0], 1'b0};
                tx_cnt   <= tx_cnt - CNT_W'(1);
            end
            if (tx_ev) io_out_q <= tx_loaded ? tx_shift[BITS-1] : 1'b0;
        end
    end

    assign bus.io_out = io_out_q;

    // ---------------- flow control ----------------
    logic cts_q, rts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_q <= 1'b1;
            rts_q <= 1'b0;
        end else begin
            cts_q <= !rx_full;
            rts_q <= tx_loaded | !tx_empty;
        end
    end

    assign bus.io_cts = cts_q;
    assign bus.io_rts = rts_q;

    // ---------------- sticky error flags (set beats clear) ----------------
    logic ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           ovr_q <= 1'b0;
        else if (rx_drop)     ovr_q <= 1'b1;
        else if (bus.err_clr) ovr_q <= 1'b0;
    end

    assign bus.rx_overrun = ovr_q;

`ifdef W6DEBUG_PARITY_EN
    logic perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           perr_q <= 1'b0;
        else if (perr_set)    perr_q <= 1'b1;
        else if (bus.err_clr) perr_q <= 1'b0;
    end

    assign bus.rx_parity_err = perr_q;
`else
    assign bus.rx_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_w6debug_link.sv
// Directed bench for w6debug_link: reset, RX word, TX word, io_clk glitches,
// direction switch, RX overrun and clear, parity (when enabled), mid-word reset.
module tb_w6debug_link;
    localparam int W   = 8;
    localparam int DEB = 15;
    localparam int PH  = 25;   // host io_clk phase length in clk cycles
`ifdef W6DEBUG_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    w6debug_link_if #(.WIDTH(W)) bus ();

    w6debug_link #(
        .WIDTH(W), .RX_DEPTH(4), .TX_DEPTH(4), .DEB_CYCLES(DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic host_bit(input logic dir, input logic b);
        bus.io_dir = dir;
        bus.io_in  = b;
        wait_clk(PH);
        bus.io_clk = 1'b1;
        wait_clk(PH);
        bus.io_clk = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic par_flip);
        for (int i = W - 1; i >= 0; i--) host_bit(1'b1, w[i]);
        if (PAR != 0) host_bit(1'b1, (^w) ^ par_flip);
        wait_clk(PH);
    endtask

    task automatic pop_chk(input string tag, input logic [W-1:0] exp);
        chk({tag, "_valid"}, bus.rx_valid, 1);
        chk(tag, bus.rx_data, exp);
        bus.rx_ready = 1'b1;
        wait_clk(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic push_tx(input logic [W-1:0] w);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        wait_clk(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic tx_word_chk(input string tag, input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            host_bit(1'b0, 1'b0);
            chk(tag, bus.io_out, w[i]);
            if (i == 1) chk({tag, "_rts_mid"}, bus.io_rts, 1);
        end
        if (PAR != 0) begin
            chk({tag, "_rts_par"}, bus.io_rts, 1);
            host_bit(1'b0, 1'b0);
            chk({tag, "_par"}, bus.io_out, ^w);
        end
        wait_clk(3);
        chk({tag, "_rts_end"}, bus.io_rts, 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.io_clk   = 1'b0;
        bus.io_dir   = 1'b0;
        bus.io_in    = 1'b0;
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        bus.err_clr  = 1'b0;
        rst_n        = 1'b0;
        wait_clk(3);
        chk("rst_cts",   bus.io_cts, 1);
        chk("rst_rts",   bus.io_rts, 0);
        chk("rst_out",   bus.io_out, 0);
        chk("rst_rxv",   bus.rx_valid, 0);
        chk("rst_txr",   bus.tx_ready, 1);
        chk("rst_ovr",   bus.rx_overrun, 0);
        chk("rst_perr",  bus.rx_parity_err, 0);
        rst_n = 1'b1;
        wait_clk(3);

        // RX single word
        send_word(8'hA5, 1'b0);
        pop_chk("rx_a5", 8'hA5);
        chk("rx_empty", bus.rx_valid, 0);

        // TX single word, MSB first: 0,0,1,1,1,1,0,0
        push_tx(8'h3C);
        wait_clk(3);
        chk("tx_rts_start", bus.io_rts, 1);
        tx_word_chk("tx_3c", 8'h3C);

        // TX word ending in 1, then an idle bit must drive 0
        push_tx(8'h81);
        wait_clk(3);
        tx_word_chk("tx_81", 8'h81);
        host_bit(1'b0, 1'b0);
        chk("tx_idle", bus.io_out, 0);

        // io_clk glitches shorter than the debounce window are ignored
        bus.io_dir = 1'b1;
        bus.io_in  = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_clk(PH);
            bus.io_clk = 1'b1;
            wait_clk(DEB - 1);
            bus.io_clk = 1'b0;
        end
        send_word(8'h5A, 1'b0);
        pop_chk("glitch_5a", 8'h5A);
        chk("glitch_one", bus.rx_valid, 0);

        // direction switch discards a partial RX word
        for (int k = 0; k < 3; k++) host_bit(1'b1, 1'b1);
        host_bit(1'b0, 1'b0);
        chk("dir_out", bus.io_out, 0);
        send_word(8'hC3, 1'b0);
        pop_chk("dir_c3", 8'hC3);

        // overrun: five words into a four-deep FIFO
        for (int k = 0; k < 5; k++) begin
            send_word(8'(8'h10 + k), 1'b0);
            if (k == 3) begin
                wait_clk(3);
                chk("ovr_cts_full", bus.io_cts, 0);
                chk("ovr_flag_pre", bus.rx_overrun, 0);
            end
        end
        chk("ovr_flag", bus.rx_overrun, 1);
        pop_chk("ovr_w0", 8'h10);
        pop_chk("ovr_w1", 8'h11);
        pop_chk("ovr_w2", 8'h12);
        pop_chk("ovr_w3", 8'h13);
        chk("ovr_drained", bus.rx_valid, 0);
        wait_clk(3);
        chk("ovr_cts_free", bus.io_cts, 1);
        bus.err_clr = 1'b1;
        wait_clk(1);
        bus.err_clr = 1'b0;
        wait_clk(1);
        chk("ovr_clr", bus.rx_overrun, 0);

`ifdef W6DEBUG_PARITY_EN
        // 0x01 with parity bit 0 is dropped, with parity bit 1 accepted
        send_word(8'h01, 1'b1);
        chk("par_err", bus.rx_parity_err, 1);
        chk("par_drop", bus.rx_valid, 0);
        chk("par_no_ovr", bus.rx_overrun, 0);
        bus.err_clr = 1'b1;
        wait_clk(1);
        bus.err_clr = 1'b0;
        wait_clk(1);
        chk("par_clr", bus.rx_parity_err, 0);
        send_word(8'h01, 1'b0);
        pop_chk("par_ok", 8'h01);
`endif

        // mid-word asynchronous reset
        push_tx(8'hFF);
        wait_clk(3);
        host_bit(1'b0, 1'b0);
        host_bit(1'b0, 1'b0);
        send_word(8'h77, 1'b0);
        for (int k = 0; k < 3; k++) host_bit(1'b1, 1'b1);
        chk("mid_pre_out", bus.io_out, 1);
        chk("mid_pre_rts", bus.io_rts, 1);
        chk("mid_pre_rxv", bus.rx_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_cts",  bus.io_cts, 1);
        chk("mid_rts",  bus.io_rts, 0);
        chk("mid_out",  bus.io_out, 0);
        chk("mid_rxv",  bus.rx_valid, 0);
        chk("mid_txr",  bus.tx_ready, 1);
        chk("mid_ovr",  bus.rx_overrun, 0);
        chk("mid_perr", bus.rx_parity_err, 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(3);
        send_word(8'h81, 1'b0);
        pop_chk("post_rst_81", 8'h81);
        chk("post_rst_empty", bus.rx_valid, 0);
        chk("post_rst_rts", bus.io_rts, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
